// File: rtl/cu_mcycle_sequencer_pkg.sv
// Shared control-unit definitions: sequencer state encoding, timing
// constants and the effective M-cycle count helper.
package cu_mcycle_sequencer_pkg;

   localparam int T_PER_M = 4;  // T-states per M-cycle (power of two)
   localparam int MAX_M   = 6;  // max M-cycles per instruction, fetch included
   localparam int IRQ_M   = 5;  // M-cycles of interrupt dispatch
   localparam int MW      = 3;  // width of the M-cycle index/count
   localparam int TW      = 2;  // width of the T-state counter

   // Last T-state of an M-cycle, and the T-state where memory is sampled
   localparam logic [TW-1:0] T_LAST   = TW'(T_PER_M - 1);
   localparam logic [TW-1:0] T_SAMPLE = TW'(2);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_IRQ   = 2'd2,
      ST_HALT  = 2'd3
   } cu_state_e;

   // Effective instruction length: an invalid opcode runs as a 1-M NOP,
   // a zero count is treated as 1 and long counts saturate at MAX_M.
   function automatic logic [MW-1:0] eff_mcycles(input logic          op_valid,
                                                 input logic [MW-1:0] op_mcycles);
      logic [MW-1:0] n;
      if (!op_valid || (op_mcycles == '0)) begin
         n = MW'(1);
      end else if (op_mcycles > MW'(MAX_M)) begin
         n = MW'(MAX_M);
      end else begin
         n = op_mcycles;
      end
      return n;
   endfunction

endpackage

// File: rtl/cu_mcycle_sequencer_tstate.sv
// T-state wrap counter. Advances on every qualified tick; a wait request
// only stalls at the memory sample point. Flags the last T of an M-cycle.
module cu_tstate_counter
   import cu_mcycle_sequencer_pkg::*;
(
   input  logic          i_Clk,
   input  logic          i_Reset,
   input  logic          i_Enable,
   input  logic          i_Wait,
   output logic [TW-1:0] o_Tstate,
   output logic          o_Tick,
   output logic          o_M_Boundary
);

   logic [TW-1:0] tstate_q;
   logic [TW-1:0] tstate_d;

   // Tick qualification and next T-state (wraps naturally at T_PER_M)
   always_comb begin
      // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
      o_Tick       = i_Enable && !(i_Wait && (tstate_q == T_SAMPLE));
      o_M_Boundary = o_Tick && (tstate_q == T_LAST);
      tstate_d     = o_Tick ? (tstate_q + TW'(1)) : tstate_q;
   end

   // T-state register with synchronous reset
   always_ff @(posedge i_Clk) begin
      // NOTE: registers are updated with non-blocking assignments so all flops see pre-edge values.
      if (i_Reset) begin
         tstate_q <= '0;
      end else begin
         tstate_q <= tstate_d;
      end
   end

   assign o_Tstate = tstate_q;

endmodule

// File: rtl/cu_mcycle_sequencer.sv
// Control-unit M-cycle sequencer: tracks fetch/execute/interrupt/halt,
// the M-cycle index within an instruction, and drives the step counter's
// enable/reset pair once per M-cycle.
module cu_mcycle_sequencer
   import cu_mcycle_sequencer_pkg::*;
(
   input  logic          i_Clk,
   input  logic          i_Reset,
   input  logic          i_Enable,
   input  logic          i_Op_Valid,
   input  logic [MW-1:0] i_Op_Mcycles,
   input  logic          i_Wait,
   input  logic          i_Halt_Req,
   input  logic          i_Irq_Pending,
   output logic [1:0]    o_Tstate,
   output logic [MW-1:0] o_Mcycle,
   output logic          o_Step_Enable,
   output logic          o_Step_Reset,
   output logic          o_Fetch,
   output logic          o_Irq_Ack,
   output logic          o_Halted,
   output logic [1:0]    o_State
);

   cu_state_e     state_q, state_d;
   logic [MW-1:0] mcycle_q, mcycle_d;
   logic [MW-1:0] n_q, n_d;
   logic [MW-1:0] n_fetch;
   logic [TW-1:0] tstate;
   logic          tick;
   logic          m_boundary;
   logic          step_en;
   logic          step_rst;

   cu_tstate_counter u_tstate (
      .i_Clk        (i_Clk),
      .i_Reset      (i_Reset),
      .i_Enable     (i_Enable),
      .i_Wait       (i_Wait),
      .o_Tstate     (tstate),
      .o_Tick       (tick),
      .o_M_Boundary (m_boundary)
   );

   assign n_fetch = eff_mcycles(i_Op_Valid, i_Op_Mcycles);

   // Next-state, M-cycle index and step-counter control at M-boundaries
   always_comb begin
      state_d  = state_q;
      mcycle_d = mcycle_q;
      n_d      = n_q;
      step_en  = 1'b0;
      step_rst = 1'b0;
      if (m_boundary) begin
         case (state_q)
            ST_FETCH: begin
               step_en = 1'b1;
               n_d     = n_fetch;
               if (i_Irq_Pending) begin
                  // Fetched opcode is dropped; dispatch starts from M0
                  state_d  = ST_IRQ;
                  mcycle_d = '0;
                  step_rst = 1'b1;
               end else if (i_Op_Valid && i_Halt_Req) begin
                  state_d  = ST_HALT;
                  mcycle_d = '0;
                  step_rst = 1'b1;
               end else if (n_fetch == MW'(1)) begin
                  step_rst = 1'b1;
               end else begin
                  state_d  = ST_EXEC;
                  mcycle_d = MW'(1);
               end
            end
            ST_EXEC: begin
               step_en = 1'b1;
               if (mcycle_q == (n_q - MW'(1))) begin
                  state_d  = ST_FETCH;
                  mcycle_d = '0;
                  step_rst = 1'b1;
               end else begin
                  mcycle_d = mcycle_q + MW'(1);
               end
            end
            ST_IRQ: begin
               step_en = 1'b1;
               if (mcycle_q == MW'(IRQ_M - 1)) begin
                  state_d  = ST_FETCH;
                  mcycle_d = '0;
                  step_rst = 1'b1;
               end else begin
                  mcycle_d = mcycle_q + MW'(1);
               end
            end
            ST_HALT: begin
               // Wake-up only returns to fetch; dispatch follows at the
               // next fetch boundary if the interrupt is still pending.
               mcycle_d = '0;
               if (i_Irq_Pending) begin
                  state_d = ST_FETCH;
               end
            end
            default: begin
               state_d  = ST_FETCH;
               mcycle_d = '0;
            end
         endcase
      end
   end

   // State, M-cycle index and latched instruction length
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q  <= ST_FETCH;
         mcycle_q <= '0;
         n_q      <= MW'(1);
      end else begin
         state_q  <= state_d;
         mcycle_q <= mcycle_d;
         n_q      <= n_d;
      end
   end

   // Reset also resets the step counter so it restarts at step 0
   assign o_Step_Enable = i_Reset | step_en;
   assign o_Step_Reset  = i_Reset | step_rst;
   assign o_Irq_Ack     = !i_Reset && tick && (state_q == ST_IRQ) &&
                          (tstate == '0) && (mcycle_q == '0);
   assign o_Fetch       = (state_q == ST_FETCH) && (mcycle_q == '0);
   assign o_Halted      = (state_q == ST_HALT);
   assign o_State       = state_q;
   assign o_Tstate      = tstate;
   assign o_Mcycle      = mcycle_q;

endmodule

// File: tb/tb_cu_mcycle_sequencer.sv
// Directed bench for cu_mcycle_sequencer: a vector table for the plain
// instruction flows, plus hand-written wait/irq/halt/reset sequences.
module tb_cu_mcycle_sequencer;

   logic       clk;
   logic       rst;
   logic       en;
   logic       valid;
   logic [2:0] mc;
   logic       wt;
   logic       halt;
   logic       irq;

   logic [1:0] dut_tstate;
   logic [2:0] dut_mcycle;
   logic       dut_se;
   logic       dut_sr;
   logic       dut_fetch;
   logic       dut_ack;
   logic       dut_halted;
   logic [1:0] dut_state;

   int vec_count  = 0;
   int miss_count = 0;

   // Expected word layout: {tstate[1:0], mcycle[2:0], step_en, step_rst,
   // fetch, irq_ack, halted, state[1:0]}
   typedef struct {
      string       name;
      logic        rst;
      logic        en;
      logic        valid;
      logic [2:0]  mc;
      logic        wt;
      logic        halt;
      logic        irq;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl[$];

   cu_mcycle_sequencer dut (
      .i_Clk         (clk),
      .i_Reset       (rst),
      .i_Enable      (en),
      .i_Op_Valid    (valid),
      .i_Op_Mcycles  (mc),
      .i_Wait        (wt),
      .i_Halt_Req    (halt),
      .i_Irq_Pending (irq),
      .o_Tstate      (dut_tstate),
      .o_Mcycle      (dut_mcycle),
      .o_Step_Enable (dut_se),
      .o_Step_Reset  (dut_sr),
      .o_Fetch       (dut_fetch),
      .o_Irq_Ack     (dut_ack),
      .o_Halted      (dut_halted),
      .o_State       (dut_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic vec_t mk(string n, logic r, logic e, logic v, logic [2:0] m_in,
                               logic w, logic h_in, logic i_in,
                               logic [1:0] t, logic [2:0] m, logic se, logic sr,
                               logic f, logic a, logic h, logic [1:0] s);
      vec_t x;
      x.name  = n;
      x.rst   = r;
      x.en    = e;
      x.valid = v;
      x.mc    = m_in;
      x.wt    = w;
      x.halt  = h_in;
      x.irq   = i_in;
      x.exp   = {t, m, se, sr, f, a, h, s};
      return x;
   endfunction

   function automatic logic [11:0] obs();
      return {dut_tstate, dut_mcycle, dut_se, dut_sr, dut_fetch, dut_ack, dut_halted, dut_state};
   endfunction

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      vec_count++;
      if (act !== exp) begin
         miss_count++;
         $display("FAIL %s @%0t: got t=%0d m=%0d se=%b sr=%b f=%b ack=%b h=%b st=%0d, want t=%0d m=%0d se=%b sr=%b f=%b ack=%b h=%b st=%0d",
                  name, $time, act[11:10], act[9:7], act[6], act[5], act[4], act[3], act[2], act[1:0],
                  exp[11:10], exp[9:7], exp[6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
      end
   endtask

   // Drive one cycle of inputs mid-period, then compare that cycle's outputs
   task automatic run_vec(input vec_t v);
      @(negedge clk);
      rst   = v.rst;
      en    = v.en;
      valid = v.valid;
      mc    = v.mc;
      wt    = v.wt;
      halt  = v.halt;
      irq   = v.irq;
      #1;
      check(v.name, obs(), v.exp);
   endtask

   // Full 20-clock interrupt dispatch starting at T0 of M0
   task automatic run_irq(input string n, input int irq_hold);
      for (int j = 0; j < 20; j++) begin
         run_vec(mk(n, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, (j < irq_hold),
                    2'(j % 4), 3'(j / 4), (j % 4 == 3), (j == 19), 1'b0, (j == 0), 1'b0, 2'd2));
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; valid = 1'b0; mc = 3'd0; wt = 1'b0; halt = 1'b0; irq = 1'b0;
      @(posedge clk);

      // ---------------- vector table ----------------
      // Reset state; reset overrides a low enable
      tbl.push_back(mk("reset", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0,
                       2'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0));
      // Four 1-M opcodes
      for (int k = 0; k < 16; k++)
         tbl.push_back(mk("op_1m", 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0,
                          2'(k % 4), 3'd0, (k % 4 == 3), (k % 4 == 3), 1'b1, 1'b0, 1'b0, 2'd0));
      // 3-M opcode; count changes during EXEC must be ignored (latched)
      for (int k = 0; k < 12; k++)
         tbl.push_back(mk("op_3m", 1'b0, 1'b1, 1'b1, (k < 4) ? 3'd3 : 3'd5, 1'b0, 1'b0, 1'b0,
                          2'(k % 4), 3'(k / 4), (k % 4 == 3), (k == 11), (k < 4),
                          1'b0, 1'b0, (k < 4) ? 2'd0 : 2'd1));
      // Count 0 behaves as 1-M
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk("op_0m", 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0,
                          2'(k), 3'd0, (k == 3), (k == 3), 1'b1, 1'b0, 1'b0, 2'd0));
      // Invalid opcode behaves as 1-M NOP
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk("op_inval", 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0,
                          2'(k), 3'd0, (k == 3), (k == 3), 1'b1, 1'b0, 1'b0, 2'd0));
      // Count 7 saturates at 6 M-cycles
      for (int k = 0; k < 24; k++)
         tbl.push_back(mk("op_7m", 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0,
                          2'(k % 4), 3'(k / 4), (k % 4 == 3), (k == 23), (k < 4),
                          1'b0, 1'b0, (k < 4) ? 2'd0 : 2'd1));

      foreach (tbl[i]) run_vec(tbl[i]);

      // ---------------- wait stall in EXEC (2-M opcode) ----------------
      for (int k = 0; k < 4; k++)
         run_vec(mk("wait_fetch", 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0,
                    2'(k), 3'd0, (k == 3), 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
      run_vec(mk("wait_at_t0", 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0,
                 2'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
      run_vec(mk("wait_t1", 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0,
                 2'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
      for (int k = 0; k < 5; k++)
         run_vec(mk("wait_stall", 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0,
                    2'd2, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
      run_vec(mk("wait_release", 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0,
                 2'd2, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
      run_vec(mk("enable_low", 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0,
                 2'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
      run_vec(mk("wait_at_t3", 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0,
                 2'd3, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1));

      // ---------------- irq and halt together: irq wins ----------------
      for (int k = 0; k < 4; k++)
         run_vec(mk("irq_halt_fetch", 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1,
                    2'(k), 3'd0, (k == 3), (k == 3), 1'b1, 1'b0, 1'b0, 2'd0));
      run_irq("irq_dispatch", 12);

      // ---------------- HALT, then wake on interrupt ----------------
      for (int k = 0; k < 4; k++)
         run_vec(mk("halt_enter", 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0,
                    2'(k), 3'd0, (k == 3), (k == 3), 1'b1, 1'b0, 1'b0, 2'd0));
      for (int k = 0; k < 40; k++)
         run_vec(mk("halt_idle", 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0,
                    2'(k % 4), 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3));
      for (int k = 0; k < 4; k++)
         run_vec(mk("halt_wake", 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1,
                    2'(k), 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3));
      for (int k = 0; k < 4; k++)
         run_vec(mk("wake_fetch", 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1,
                    2'(k), 3'd0, (k == 3), (k == 3), 1'b1, 1'b0, 1'b0, 2'd0));
      run_irq("wake_dispatch", 0);

      // ---------------- reset at T2 of M3 ----------------
      for (int k = 0; k < 14; k++)
         run_vec(mk("rst_mid_run", 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0,
                    2'(k % 4), 3'(k / 4), (k % 4 == 3), 1'b0, (k < 4),
                    1'b0, 1'b0, (k < 4) ? 2'd0 : 2'd1));
      run_vec(mk("rst_mid_assert", 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0,
                 2'd2, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
      run_vec(mk("rst_mid_after", 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0,
                 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
      run_vec(mk("rst_mid_after2", 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0,
                 2'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
